// File: rtl/writeback_arbiter.sv
// Writeback stage feeding the register-file write port: single-cycle ALU results take priority,
// long-latency LSU/MUL results are queued in a small FIFO, and a starvation guard asks for a bubble.
module writeback_arbiter #(
   parameter int width      = 32,
   parameter int DEPTH      = 2,
   parameter int STARVE_MAX = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       alu_valid,
   input  logic [4:0]                 alu_addr,
   input  logic [width-1:0]           alu_data,
   input  logic                       lsu_valid,
   output logic                       lsu_ready,
   input  logic [4:0]                 lsu_addr,
   input  logic [width-1:0]           lsu_data,
   output logic                       rf_en,
   output logic [4:0]                 write_addr,
   output logic [width-1:0]           write_data,
   output logic                       stall_req,
   output logic [$clog2(DEPTH+1)-1:0] fifo_count
);
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int STV_W = $clog2(STARVE_MAX + 1);

   logic [4:0]       fifo_addr_mem [DEPTH];
   logic [width-1:0] fifo_data_mem [DEPTH];
   logic [PTR_W-1:0] head_reg, tail_reg;
   logic [CNT_W-1:0] count_reg;
   logic [STV_W-1:0] starve_reg, starve_next;
   logic             stall_reg, stall_next;
   logic             rf_en_reg;
   logic [4:0]       addr_reg;
   logic [width-1:0] data_reg;

   logic             transfer, push, pop;
   logic             sel_valid;
   logic [4:0]       sel_addr;
   logic [width-1:0] sel_data;

   // Ready depends only on occupancy; a full FIFO never accepts even if it pops this cycle.
   assign lsu_ready = !rst && (count_reg < CNT_W'(DEPTH));
   assign transfer  = lsu_valid && lsu_ready;

   always_comb begin
      sel_valid = 1'b0;
      sel_addr  = '0;
      sel_data  = '0;
      push      = 1'b0;
      pop       = 1'b0;
      if (alu_valid) begin
         sel_valid = 1'b1;
         sel_addr  = alu_addr;
         sel_data  = alu_data;
         push      = transfer;
      end else if (count_reg != '0) begin
         sel_valid = 1'b1;
         sel_addr  = fifo_addr_mem[head_reg];
         sel_data  = fifo_data_mem[head_reg];
         pop       = 1'b1;
         push      = transfer;
      end else if (transfer) begin
         // Empty FIFO and idle ALU: forward the LSU result straight through.
         sel_valid = 1'b1;
         sel_addr  = lsu_addr;
         sel_data  = lsu_data;
      end
   end

   always_comb begin
      starve_next = starve_reg;
      stall_next  = 1'b0;
      if (pop || count_reg == '0) begin
         starve_next = '0;
      end else if (alu_valid) begin
         starve_next = STV_W'(starve_reg + 1'b1);
      end
      if (starve_next == STV_W'(STARVE_MAX)) begin
         stall_next  = 1'b1;
         starve_next = '0;
      end
   end

   // Storage needs no reset: occupancy is tracked by count/pointers alone.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_addr_mem[tail_reg] <= lsu_addr;
         fifo_data_mem[tail_reg] <= lsu_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         head_reg   <= '0;
         tail_reg   <= '0;
         count_reg  <= '0;
         starve_reg <= '0;
         stall_reg  <= 1'b0;
         rf_en_reg  <= 1'b0;
         addr_reg   <= '0;
         data_reg   <= '0;
      end else begin
         if (push) begin
            tail_reg <= (tail_reg == PTR_W'(DEPTH - 1)) ? '0 : PTR_W'(tail_reg + 1'b1);
         end
         if (pop) begin
            head_reg <= (head_reg == PTR_W'(DEPTH - 1)) ? '0 : PTR_W'(head_reg + 1'b1);
         end
         case ({push, pop})
            2'b10:   count_reg <= CNT_W'(count_reg + 1'b1);
            2'b01:   count_reg <= CNT_W'(count_reg - 1'b1);
            default: count_reg <= count_reg;
         endcase
         starve_reg <= starve_next;
         stall_reg  <= stall_next;
         // Writes to x0 are consumed but never enable the register file.
         rf_en_reg  <= sel_valid && (sel_addr != 5'd0);
         if (sel_valid) begin
            addr_reg <= sel_addr;
            data_reg <= sel_data;
         end
      end
   end

   assign rf_en      = rf_en_reg;
   assign write_addr = addr_reg;
   assign write_data = data_reg;
   assign stall_req  = stall_reg;
   assign fifo_count = count_reg;

endmodule

// File: tb/tb_writeback_arbiter.sv
// Self-checking bench for writeback_arbiter: table-driven per-cycle vectors with a scoreboard queue,
// plus hand-written reset sequences.
module tb_writeback_arbiter;
   logic        clk = 1'b0;
   logic        rst;
   logic        alu_valid;
   logic [4:0]  alu_addr;
   logic [31:0] alu_data;
   logic        lsu_valid;
   logic        lsu_ready;
   logic [4:0]  lsu_addr;
   logic [31:0] lsu_data;
   logic        rf_en;
   logic [4:0]  write_addr;
   logic [31:0] write_data;
   logic        stall_req;
   logic [1:0]  fifo_count;

   int n_checks = 0;
   int n_fail   = 0;

   writeback_arbiter #(.width(32), .DEPTH(2), .STARVE_MAX(4)) dut (
      .clk(clk), .rst(rst),
      .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data),
      .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_addr(lsu_addr), .lsu_data(lsu_data),
      .rf_en(rf_en), .write_addr(write_addr), .write_data(write_data),
      .stall_req(stall_req), .fifo_count(fifo_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        alu_v;
      logic [4:0]  alu_a;
      logic [31:0] alu_d;
      logic        lsu_v;
      logic [4:0]  lsu_a;
      logic [31:0] lsu_d;
      logic        exp_ready;
      logic        exp_en;
      logic [4:0]  exp_addr;
      logic [31:0] exp_data;
      logic [1:0]  exp_count;
      logic        exp_stall;
   } vec_t;

   vec_t sb_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Drive one cycle of inputs, check ready, queue expectation, then compare registered outputs.
   task automatic run_vec(input string tag, input vec_t v);
      vec_t e;
      alu_valid = v.alu_v; alu_addr = v.alu_a; alu_data = v.alu_d;
      lsu_valid = v.lsu_v; lsu_addr = v.lsu_a; lsu_data = v.lsu_d;
      #1;
      check({tag, ".lsu_ready"}, lsu_ready, v.exp_ready);
      sb_q.push_back(v);
      @(posedge clk);
      #1;
      e = sb_q.pop_front();
      check({tag, ".rf_en"},      rf_en,      e.exp_en);
      check({tag, ".write_addr"}, write_addr, e.exp_addr);
      check({tag, ".write_data"}, write_data, e.exp_data);
      check({tag, ".fifo_count"}, fifo_count, e.exp_count);
      check({tag, ".stall_req"},  stall_req,  e.exp_stall);
      $display("%s: alu_v=%0b lsu_v=%0b -> rf_en=%0b addr=%0d data=%h count=%0d stall=%0b",
               tag, v.alu_v, v.lsu_v, rf_en, write_addr, write_data, fifo_count, stall_req);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      vec_t basic[10];
      vec_t starve[8];
      vec_t zero_head[3];
      vec_t fill[2];

      //            alu_v alu_a  alu_d          lsu_v lsu_a  lsu_d         rdy en addr   data           cnt  stall
      basic[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0,  32'h0,        1,  1, 5'd5,  32'hDEADBEEF, 2'd0, 0};
      basic[1] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd7,  32'h1234,     1,  1, 5'd7,  32'h1234,     2'd0, 0};
      basic[2] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1,  0, 5'd7,  32'h1234,     2'd0, 0};
      basic[3] = '{1'b1, 5'd0,  32'h55,       1'b0, 5'd0,  32'h0,        1,  0, 5'd0,  32'h55,       2'd0, 0};
      basic[4] = '{1'b1, 5'd3,  32'hAAAA,     1'b1, 5'd9,  32'hBBBB,     1,  1, 5'd3,  32'hAAAA,     2'd1, 0};
      basic[5] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1,  1, 5'd9,  32'hBBBB,     2'd0, 0};
      basic[6] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd0,  32'hCCCC,     1,  0, 5'd0,  32'hCCCC,     2'd0, 0};
      basic[7] = '{1'b1, 5'd10, 32'h1,        1'b1, 5'd11, 32'h2,        1,  1, 5'd10, 32'h1,        2'd1, 0};
      basic[8] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd12, 32'h3,        1,  1, 5'd11, 32'h2,        2'd1, 0};
      basic[9] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1,  1, 5'd12, 32'h3,        2'd0, 0};

      // ALU every cycle while LSU offers 1,2,3; stall bubble after four blocked cycles drains in order.
      starve[0] = '{1'b1, 5'd20, 32'hA0, 1'b1, 5'd1, 32'h1001, 1, 1, 5'd20, 32'hA0,   2'd1, 0};
      starve[1] = '{1'b1, 5'd21, 32'hA1, 1'b1, 5'd2, 32'h1002, 1, 1, 5'd21, 32'hA1,   2'd2, 0};
      starve[2] = '{1'b1, 5'd22, 32'hA2, 1'b1, 5'd3, 32'h1003, 0, 1, 5'd22, 32'hA2,   2'd2, 0};
      starve[3] = '{1'b1, 5'd23, 32'hA3, 1'b1, 5'd3, 32'h1003, 0, 1, 5'd23, 32'hA3,   2'd2, 0};
      starve[4] = '{1'b1, 5'd24, 32'hA4, 1'b1, 5'd3, 32'h1003, 0, 1, 5'd24, 32'hA4,   2'd2, 1};
      starve[5] = '{1'b0, 5'd0,  32'h0,  1'b1, 5'd3, 32'h1003, 0, 1, 5'd1,  32'h1001, 2'd1, 0};
      starve[6] = '{1'b0, 5'd0,  32'h0,  1'b1, 5'd3, 32'h1003, 1, 1, 5'd2,  32'h1002, 2'd1, 0};
      starve[7] = '{1'b0, 5'd0,  32'h0,  1'b0, 5'd0, 32'h0,    1, 1, 5'd3,  32'h1003, 2'd0, 0};

      // FIFO head targeting x0 behind ALU writes: consumed with rf_en low.
      zero_head[0] = '{1'b1, 5'd4, 32'h44, 1'b1, 5'd0, 32'hF00D, 1, 1, 5'd4, 32'h44,   2'd1, 0};
      zero_head[1] = '{1'b1, 5'd6, 32'h66, 1'b0, 5'd0, 32'h0,    1, 1, 5'd6, 32'h66,   2'd1, 0};
      zero_head[2] = '{1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,    1, 0, 5'd0, 32'hF00D, 2'd0, 0};

      fill[0] = '{1'b1, 5'd1, 32'h11, 1'b1, 5'd13, 32'hD13, 1, 1, 5'd1, 32'h11, 2'd1, 0};
      fill[1] = '{1'b1, 5'd2, 32'h22, 1'b1, 5'd14, 32'hD14, 1, 1, 5'd2, 32'h22, 2'd2, 0};

      // Reset held three cycles with an LSU offer present.
      rst = 1'b1;
      alu_valid = 1'b0; alu_addr = '0; alu_data = '0;
      lsu_valid = 1'b1; lsu_addr = 5'd1; lsu_data = 32'h99;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         check("rst.lsu_ready", lsu_ready, 1'b0);
         check("rst.rf_en", rf_en, 1'b0);
         check("rst.fifo_count", fifo_count, 2'd0);
         $display("reset cycle %0d: lsu_ready=%0b rf_en=%0b count=%0d", i, lsu_ready, rf_en, fifo_count);
      end
      check("rst.write_addr", write_addr, 5'd0);
      check("rst.write_data", write_data, 32'd0);
      check("rst.stall_req", stall_req, 1'b0);
      rst = 1'b0;
      lsu_valid = 1'b0;
      #1;
      check("post_rst.lsu_ready", lsu_ready, 1'b1);
      $display("reset released: lsu_ready=%0b", lsu_ready);

      for (int i = 0; i < 10; i++) run_vec($sformatf("basic[%0d]", i), basic[i]);
      for (int i = 0; i < 8; i++)  run_vec($sformatf("starve[%0d]", i), starve[i]);
      for (int i = 0; i < 3; i++)  run_vec($sformatf("x0_head[%0d]", i), zero_head[i]);
      for (int i = 0; i < 2; i++)  run_vec($sformatf("fill[%0d]", i), fill[i]);

      // Reset with two queued entries: they must vanish without ever being written.
      rst = 1'b1;
      alu_valid = 1'b0;
      lsu_valid = 1'b1; lsu_addr = 5'd15; lsu_data = 32'hD15;
      #1;
      check("midrst.lsu_ready", lsu_ready, 1'b0);
      @(posedge clk);
      #1;
      check("midrst.fifo_count", fifo_count, 2'd0);
      check("midrst.rf_en", rf_en, 1'b0);
      $display("mid-run reset: count=%0d rf_en=%0b", fifo_count, rf_en);
      rst = 1'b0;
      lsu_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         check("after_rst.rf_en", rf_en, 1'b0);
         check("after_rst.fifo_count", fifo_count, 2'd0);
         $display("after reset cycle %0d: rf_en=%0b count=%0d", i, rf_en, fifo_count);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
